pipelined_add_sub: RTL

PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

---
 rtl/pipelined_add_sub_pkg.sv | 7 +
 rtl/pipelined_add_sub_if.sv | 29 ++
 rtl/pipelined_add_sub_slice.sv | 19 +
 rtl/pipelined_add_sub.sv | 127 ++++++++++++
 4 files changed

// File: rtl/pipelined_add_sub_pkg.sv
// Shared constants for the pipelined adder/subtractor.
package adder_pkg;
  localparam int   DEFAULT_WIDTH  = 32;
  localparam int   DEFAULT_STAGES = 4;
  localparam logic OP_ADD         = 1'b0;
  localparam logic OP_SUB         = 1'b1;
endpackage

// File: rtl/pipelined_add_sub_if.sv
// Operand/result stream of the pipelined adder: valid/ready in, valid/ready out.
interface pipelined_add_sub_if
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, b, cin, sub, in_valid, out_ready,
    input  in_ready, sum, cout, ovf, zero, out_valid
  );

  modport slave (
    input  a, b, cin, sub, in_valid, out_ready,
    output in_ready, sum, cout, ovf, zero, out_valid
  );
endinterface

// File: rtl/pipelined_add_sub_slice.sv
// One CHUNK-bit ripple slice; msb_cin is the carry into the slice's top bit.
module add_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);
  logic [CHUNK:0] total;

  assign total   = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum     = total[CHUNK-1:0];
  assign cout    = total[CHUNK];
  // a ^ b ^ sum at a bit position recovers the carry that entered it
  assign msb_cin = a[CHUNK-1] ^ b[CHUNK-1] ^ total[CHUNK-1];
endmodule

// File: rtl/pipelined_add_sub.sv
// Carry-pipelined add/sub: one CHUNK slice per stage, operands skewed up, results deskewed.
module pipelined_add_sub
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input logic                clk,
  input logic                rst,
  pipelined_add_sub_if.slave io
);
  localparam int SAFE_STAGES = (STAGES < 1) ? 1 : STAGES;
  localparam int CHUNK       = WIDTH / SAFE_STAGES;

  if (STAGES < 1 || (WIDTH % SAFE_STAGES) != 0) begin : g_bad_params
    $fatal(1, "pipelined_add_sub: STAGES must be >= 1 and divide WIDTH");
  end

  logic             advance;
  logic             out_valid;
  logic [WIDTH-1:0] b_eff;

  assign b_eff       = (io.sub == OP_SUB) ? ~io.b : io.b;
  assign advance     = !out_valid || io.out_ready;
  assign io.in_ready = advance || rst;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int DONE = (gi + 1) * CHUNK;

    logic [CHUNK-1:0] op_a;
    logic [CHUNK-1:0] op_b;
    logic [CHUNK-1:0] slice_sum;
    logic             carry_in;
    logic             valid_in;
    logic             slice_cout;
    logic             slice_msb_cin;
    logic [DONE-1:0]  sum_next;
    logic [DONE-1:0]  sum_reg;
    logic             carry_reg;
    logic             valid_reg;

    if (gi == 0) begin : g_head
      assign op_a     = io.a[CHUNK-1:0];
      assign op_b     = b_eff[CHUNK-1:0];
      assign carry_in = io.cin ^ io.sub;
      assign valid_in = io.in_valid;
      assign sum_next = slice_sum;
    end else begin : g_body
      assign op_a     = g_stage[gi-1].g_skew.a_reg[CHUNK-1:0];
      assign op_b     = g_stage[gi-1].g_skew.b_reg[CHUNK-1:0];
      assign carry_in = g_stage[gi-1].carry_reg;
      assign valid_in = g_stage[gi-1].valid_reg;
      assign sum_next = {slice_sum, g_stage[gi-1].sum_reg};
    end

    add_slice #(.CHUNK(CHUNK)) u_slice (
      .a       (op_a),
      .b       (op_b),
      .cin     (carry_in),
      .sum     (slice_sum),
      .cout    (slice_cout),
      .msb_cin (slice_msb_cin)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        sum_reg   <= '0;
        carry_reg <= 1'b0;
        valid_reg <= 1'b0;
      end else if (advance) begin
        sum_reg   <= sum_next;
        carry_reg <= slice_cout;
        valid_reg <= valid_in;
      end
    end

    // Operand bits not yet consumed ride along until their slice's stage
    if (gi < STAGES - 1) begin : g_skew
      localparam int REM = WIDTH - DONE;

      logic [REM-1:0] a_next;
      logic [REM-1:0] b_next;
      logic [REM-1:0] a_reg;
      logic [REM-1:0] b_reg;

      if (gi == 0) begin : g_src_in
        assign a_next = io.a[WIDTH-1:CHUNK];
        assign b_next = b_eff[WIDTH-1:CHUNK];
      end else begin : g_src_prev
        assign a_next = g_stage[gi-1].g_skew.a_reg[REM+CHUNK-1:CHUNK];
        assign b_next = g_stage[gi-1].g_skew.b_reg[REM+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (advance) begin
          a_reg <= a_next;
          b_reg <= b_next;
        end
      end
    end

    if (gi == STAGES - 1) begin : g_tail
      logic ovf_reg;
      logic zero_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_reg  <= 1'b0;
          zero_reg <= 1'b0;
        end else if (advance) begin
          ovf_reg  <= slice_cout ^ slice_msb_cin;
          zero_reg <= (sum_next == '0);
        end
      end
    end
  end

  assign out_valid    = g_stage[STAGES-1].valid_reg;
  assign io.out_valid = out_valid;
  assign io.sum       = g_stage[STAGES-1].sum_reg;
  assign io.cout      = g_stage[STAGES-1].carry_reg;
  assign io.ovf       = g_stage[STAGES-1].g_tail.ovf_reg;
  assign io.zero      = g_stage[STAGES-1].g_tail.zero_reg;
endmodule
